// File: rtl/dpram_pkg.sv
// Shared types and helpers for the dual-port RAM controller.
package dpram_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic bit rd_lat_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

  // Both ports writing the same word in the same cycle.
  function automatic logic is_coll(input logic we_a, input logic we_b,
                                   input logic [31:0] addr_a, input logic [31:0] addr_b);
    return we_a & we_b & (addr_a == addr_b);
  endfunction

endpackage

// File: rtl/dpram_if.sv
// One memory access port: request/write side plus ready and read-return side.
interface dpram_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ready, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/dpram_core.sv
// Plain true dual-port array with registered reads; read-before-write on each port.
module dpram_core #(
  parameter int AW     = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              i_clk,
  input  logic [AW-1:0]     i_addr_a,
  input  logic [DATA_W-1:0] i_wdata_a,
  input  logic              i_wren_a,
  output logic [DATA_W-1:0] o_q_a,
  input  logic [AW-1:0]     i_addr_b,
  input  logic [DATA_W-1:0] i_wdata_b,
  input  logic              i_wren_b,
  output logic [DATA_W-1:0] o_q_b
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wren_a) r_mem[i_addr_a] <= i_wdata_a;
    if (i_wren_b) r_mem[i_addr_b] <= i_wdata_b;
    o_q_a <= r_mem[i_addr_a];
    o_q_b <= r_mem[i_addr_b];
  end

endmodule

// File: rtl/dpram_ctrl.sv
// Dual-port RAM controller: handshake, range check, write-collision mask, read pipeline.
// Optional post-reset clear sweep built when DPRAM_INIT_CLEAR_EN is defined.
module dpram_ctrl
  import dpram_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic    clock,
  input  logic    reset_n,
  dpram_if.slave  port_a,
  dpram_if.slave  port_b,
  output logic    coll_err,
  output logic    init_busy
);

  // Illegal latencies fall back to a single stage.
  localparam int LAT = rd_lat_ok(RD_LAT) ? RD_LAT : 1;
  localparam int AW  = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  state_t r_state;
  logic   r_ready;
  logic   r_coll;

  logic [1:0]             w_req, w_we, w_acc, w_inr, w_rd, w_wr, w_rvalid;
  logic [1:0][ADDR_W-1:0] w_addr;
  logic [1:0][DATA_W-1:0] w_wdata, w_q, w_rdata;
  logic                   w_coll;
  logic                   w_clr;
  logic [AW-1:0]          w_clr_addr;

  assign w_req   = {port_b.req, port_a.req};
  assign w_we    = {port_b.we, port_a.we};
  assign w_addr  = {port_b.addr, port_a.addr};
  assign w_wdata = {port_b.wdata, port_a.wdata};
  assign w_acc   = w_req & {2{r_ready}};
  assign w_rd    = w_acc & ~w_we;

  for (genvar p = 0; p < 2; p++) begin : g_rng
    assign w_inr[p] = ({1'b0, w_addr[p]} < (ADDR_W+1)'(DEPTH));
  end

  // Port A wins a same-address write; B's write is masked off.
  assign w_coll = is_coll(w_acc[0] & w_we[0] & w_inr[0], w_acc[1] & w_we[1] & w_inr[1],
                          32'(w_addr[0]), 32'(w_addr[1]));
  assign w_wr[0] = w_acc[0] & w_we[0] & w_inr[0];
  assign w_wr[1] = w_acc[1] & w_we[1] & w_inr[1] & ~w_coll;

  dpram_core #(.AW(AW), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_core (
    .i_clk     (clock),
    .i_addr_a  (w_clr ? w_clr_addr : w_addr[0][AW-1:0]),
    .i_wdata_a (w_clr ? '0 : w_wdata[0]),
    .i_wren_a  (w_clr | w_wr[0]),
    .o_q_a     (w_q[0]),
    .i_addr_b  (w_clr ? (w_clr_addr | AW'(1)) : w_addr[1][AW-1:0]),
    .i_wdata_b (w_clr ? '0 : w_wdata[1]),
    .i_wren_b  (w_clr | w_wr[1]),
    .o_q_b     (w_q[1])
  );

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [LAT-1:0]    r_vld;
    logic              r_oor;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] w_q1;

    assign w_q1 = r_oor ? '0 : w_q[p];

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_vld  <= '0;
        r_oor  <= 1'b0;
        r_hold <= '0;
      end else begin
        r_vld <= LAT'({r_vld, w_rd[p]});
        r_oor <= ~w_inr[p];
        if (r_vld[0]) r_hold <= w_q1;
      end
    end

    assign w_rvalid[p] = r_vld[LAT-1];
    // Single-stage reads bypass the hold register so rdata lines up with rvalid.
    if (LAT == 1) begin : g_l1
      assign w_rdata[p] = r_vld[0] ? w_q1 : r_hold;
    end else begin : g_l2
      assign w_rdata[p] = r_hold;
    end
  end

`ifdef DPRAM_INIT_CLEAR_EN
  logic          r_busy;
  logic [AW-1:0] r_clr_addr;

  assign w_clr      = (r_state == ST_CLEAR);
  assign w_clr_addr = r_clr_addr;
  assign init_busy  = r_busy;
`else
  assign w_clr      = 1'b0;
  assign w_clr_addr = '0;
  assign init_busy  = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_RESET;
      r_ready    <= 1'b0;
      r_coll     <= 1'b0;
`ifdef DPRAM_INIT_CLEAR_EN
      r_busy     <= 1'b0;
      r_clr_addr <= '0;
`endif
    end else begin
      r_coll <= w_coll;
      case (r_state)
        ST_RESET: begin
`ifdef DPRAM_INIT_CLEAR_EN
          r_state    <= ST_CLEAR;
          r_busy     <= 1'b1;
          r_clr_addr <= '0;
`else
          r_state <= ST_RUN;
          r_ready <= 1'b1;
`endif
        end
`ifdef DPRAM_INIT_CLEAR_EN
        // Two words per cycle, so the sweep walks even addresses only.
        ST_CLEAR: begin
          if (r_clr_addr == AW'(DEPTH - 2)) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_clr_addr <= r_clr_addr + AW'(2);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign coll_err      = r_coll;
  assign port_a.ready  = r_ready;
  assign port_b.ready  = r_ready;
  assign port_a.rvalid = w_rvalid[0];
  assign port_b.rvalid = w_rvalid[1];
  assign port_a.rdata  = w_rdata[0];
  assign port_b.rdata  = w_rdata[1];

endmodule

// File: tb/tb_dpram_ctrl.sv
// Scoreboard bench: dut0 (ADDR_W=5, DEPTH=16, RD_LAT=1), dut1 (ADDR_W=4, RD_LAT=2).
module tb_dpram_ctrl;
  import dpram_pkg::*;

`ifdef DPRAM_INIT_CLEAR_EN
  localparam int NB = 8;
`else
  localparam int NB = 0;
`endif

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cycle = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  logic       req_a[2], we_a[2], req_b[2], we_b[2];
  logic [4:0] addr_a[2], addr_b[2];
  logic [7:0] wdata_a[2], wdata_b[2];
  logic       coll[2], busy[2];

  exp_t q0[$], q1[$], q2[$], q3[$];
  int   qc0[$], qc1[$];

  dpram_if #(.ADDR_W(5), .DATA_W(8)) ia0 ();
  dpram_if #(.ADDR_W(5), .DATA_W(8)) ib0 ();
  dpram_if #(.ADDR_W(4), .DATA_W(8)) ia1 ();
  dpram_if #(.ADDR_W(4), .DATA_W(8)) ib1 ();

  assign ia0.req = req_a[0];  assign ia0.we = we_a[0];
  assign ia0.addr = addr_a[0]; assign ia0.wdata = wdata_a[0];
  assign ib0.req = req_b[0];  assign ib0.we = we_b[0];
  assign ib0.addr = addr_b[0]; assign ib0.wdata = wdata_b[0];
  assign ia1.req = req_a[1];  assign ia1.we = we_a[1];
  assign ia1.addr = addr_a[1][3:0]; assign ia1.wdata = wdata_a[1];
  assign ib1.req = req_b[1];  assign ib1.we = we_b[1];
  assign ib1.addr = addr_b[1][3:0]; assign ib1.wdata = wdata_b[1];

  dpram_ctrl #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1), .DEPTH(16)) dut0 (
    .clock(clk), .reset_n(reset_n), .port_a(ia0), .port_b(ib0),
    .coll_err(coll[0]), .init_busy(busy[0]));

  dpram_ctrl #(.ADDR_W(4), .DATA_W(8), .RD_LAT(2), .DEPTH(16)) dut1 (
    .clock(clk), .reset_n(reset_n), .port_a(ia1), .port_b(ib1),
    .coll_err(coll[1]), .init_busy(busy[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic logic [7:0] pat(input int a);
    return (a < 8) ? 8'(8'hA0 + a) : 8'(8'hB0 + a - 8);
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h cycle=%0d", nm, got, exp, cycle);
  endtask

  task automatic push_exp(input int s, input logic [7:0] d, input int c);
    exp_t e;
    e.data = d; e.cyc = c;
    case (s)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int s);
    case (s)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic exp_t qfront(input int s);
    case (s)
      0: return q0[0];
      1: return q1[0];
      2: return q2[0];
      default: return q3[0];
    endcase
  endfunction

  function automatic exp_t qpop(input int s);
    case (s)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  task automatic mon(input int s, input logic v, input logic [7:0] dat);
    exp_t e;
    while (qsize(s) > 0 && qfront(s).cyc < cycle) begin
      e = qpop(s);
      n_chk++;
      $display("FAIL rvalid_missing stream=%0d got=none exp_cycle=%0d data=%0h", s, e.cyc, e.data);
    end
    if (v === 1'b1) begin
      if (qsize(s) == 0) begin
        n_chk++;
        $display("FAIL rvalid_unexpected stream=%0d got=%0h exp=none cycle=%0d", s, dat, cycle);
      end else begin
        e = qpop(s);
        check($sformatf("rdata_s%0d", s), 32'(dat), 32'(e.data));
        check($sformatf("rvalid_cycle_s%0d", s), cycle, e.cyc);
      end
    end else if (v !== 1'b0) begin
      check($sformatf("rvalid_known_s%0d", s), 32'(v), 0);
    end
  endtask

  task automatic monc(input int d, input logic v);
    int c;
    if (d == 0) begin
      while (qc0.size() > 0 && qc0[0] < cycle) begin
        c = qc0.pop_front(); n_chk++;
        $display("FAIL coll_missing dut=0 got=none exp_cycle=%0d", c);
      end
      if (v !== 1'b0) begin
        if (qc0.size() == 0) check("coll_unexpected_d0", 32'(v), 0);
        else begin c = qc0.pop_front(); check("coll_cycle_d0", cycle, c); end
      end
    end else begin
      while (qc1.size() > 0 && qc1[0] < cycle) begin
        c = qc1.pop_front(); n_chk++;
        $display("FAIL coll_missing dut=1 got=none exp_cycle=%0d", c);
      end
      if (v !== 1'b0) begin
        if (qc1.size() == 0) check("coll_unexpected_d1", 32'(v), 0);
        else begin c = qc1.pop_front(); check("coll_cycle_d1", cycle, c); end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, ia0.rvalid, ia0.rdata);
    mon(1, ib0.rvalid, ib0.rdata);
    mon(2, ia1.rvalid, ia1.rdata);
    mon(3, ib1.rvalid, ib1.rdata);
    monc(0, coll[0]);
    monc(1, coll[1]);
  end

  // One cycle on DUT d; read expectations are pushed with their due cycle.
  task automatic drive(input int d,
                       input logic ra, input logic wa, input logic [4:0] aa,
                       input logic [7:0] da, input logic [7:0] ea,
                       input logic rb, input logic wb, input logic [4:0] ab,
                       input logic [7:0] db, input logic [7:0] eb, input bit push);
    req_a[d] = ra; we_a[d] = wa; addr_a[d] = aa; wdata_a[d] = da;
    req_b[d] = rb; we_b[d] = wb; addr_b[d] = ab; wdata_b[d] = db;
    if (push && ra && !wa) push_exp(2*d, ea, cycle + lat(d));
    if (push && rb && !wb) push_exp(2*d + 1, eb, cycle + lat(d));
    @(posedge clk); @(negedge clk);
    req_a[d] = 1'b0; req_b[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ready_a0"}, 32'(ia0.ready), 0);
    check({tag, "_rvalid_b1"}, 32'(ib1.rvalid), 0);
    check({tag, "_rdata_a0"}, 32'(ia0.rdata), 0);
    check({tag, "_rdata_b1"}, 32'(ib1.rdata), 0);
    check({tag, "_coll0"}, 32'(coll[0]), 0);
    check({tag, "_busy1"}, 32'(busy[1]), 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_a[d] = 0; we_a[d] = 0; addr_a[d] = 0; wdata_a[d] = 0;
      req_b[d] = 0; we_b[d] = 0; addr_b[d] = 0; wdata_b[d] = 0;
    end
    idle(2);
    check_reset_outs("rst");
    reset_n = 1'b1;
    for (int i = 0; i <= NB; i++) begin
      @(negedge clk);
      check($sformatf("busy0_i%0d", i), 32'(busy[0]), 32'(i < NB));
      check($sformatf("ready0_i%0d", i), 32'(ia0.ready), 32'(i == NB));
      check($sformatf("ready1_i%0d", i), 32'(ib1.ready), 32'(i == NB));
    end

`ifdef DPRAM_INIT_CLEAR_EN
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 0, 5'(i), 0, 8'h00, 0, 0, 0, 0, 0, 1);
      drive(1, 0, 0, 0, 0, 0, 1, 0, 5'(i), 0, 8'h00, 1);
    end
`endif

    // Basic latency on both latencies
    for (int d = 0; d < 2; d++) begin
      drive(d, 1, 1, 5'd3, 8'h5A, 0, 0, 0, 0, 0, 0, 1);
      drive(d, 0, 0, 0, 0, 0, 1, 0, 5'd3, 0, 8'h5A, 1);
    end
    idle(3);

    // Write collision: A's data stored, one coll pulse
    qc0.push_back(cycle + 1);
    drive(0, 1, 1, 5'd7, 8'h11, 0, 1, 1, 5'd7, 8'h22, 0, 1);
    drive(0, 1, 0, 5'd7, 0, 8'h11, 1, 0, 5'd7, 0, 8'h11, 1);

    // Read-before-write
    drive(0, 1, 1, 5'd9, 8'h33, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 1, 5'd9, 8'h44, 0, 1, 0, 5'd9, 0, 8'h33, 1);
    drive(0, 1, 0, 5'd9, 0, 8'h44, 0, 0, 0, 0, 0, 1);

    // Out of range: address 16 aliases nothing
    drive(0, 1, 1, 5'd0, 8'h66, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 1, 5'd16, 8'hEE, 0, 1, 1, 5'd16, 8'hDD, 0, 1);
    drive(0, 1, 0, 5'd16, 0, 8'h00, 1, 0, 5'd0, 0, 8'h66, 1);
    idle(3);

    // Throughput: fill, then 16 back-to-back reads per port
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++)
        drive(d, 1, 1, 5'(i), pat(i), 0, 1, 1, 5'(8+i), pat(8+i), 0, 1);
      for (int i = 0; i < 16; i++)
        drive(d, 1, 0, 5'(i), 0, pat(i), 1, 0, 5'(15-i), 0, pat(15-i), 1);
      idle(4);
    end

    // Reset with a read in flight on the two-stage DUT
    drive(1, 1, 0, 5'd5, 0, 0, 1, 0, 5'd6, 0, 0, 0);
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_reset_outs($sformatf("midrst%0d", i));
    end
    reset_n = 1'b1;
    for (int i = 0; i < 40 && ia1.ready !== 1'b1; i++) @(negedge clk);
    check("ready_after_rst", 32'(ia1.ready), 1);
    drive(1, 1, 1, 5'd2, 8'hC3, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 5'd2, 0, 8'hC3, 0, 0, 0, 0, 0, 1);
    idle(5);

    for (int s = 0; s < 4; s++) check($sformatf("q_empty_s%0d", s), qsize(s), 0);
    check("qc_empty", qc0.size() + qc1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
